config_report_tx: RTL and testbench
===================================

// Module: config_report_tx
// PURPOSE
//  Transmit side of the configuration link. On request, snapshots the five stored
//  configuration words and serializes them onto the serial line. Order is temp1,
//  temp2, temp3, temp4, lim_um, which matches the order the config receiver expects.
//  Each word goes out as one frame: start(0), DATA_BITS data LSB-first, even parity, stop(1).
//  Sits beside the config receiver; the host uses it to read back the active config.
// PARAMETERS
//  DATA_BITS     7    payload bits per frame (parity computed over these only)
//  CLKS_PER_BIT  434  clock cycles per serial bit (50 MHz / 115200)
// PORTS
//  clock          in   1          system clock, all logic on rising edge
//  reset          in   1          synchronous, active-high
//  enviar_config  in   1          request to transmit; level sampled, acted on in INICIAL only
//  temp1..temp4   in   DATA_BITS  stored temperature thresholds (4 separate ports)
//  lim_um         in   DATA_BITS  stored humidity limit
//  saida_serial   out  1          serial line, idle high
//  ocupado        out  1          high from acceptance until pronto_envio
//  pronto_envio   out  1          one-cycle pulse after stop bit of the 5th frame
//  db_estado      out  3          current FSM state code (debug)
// BEHAVIOUR
//  Reset: saida_serial=1; ocupado=0; pronto_envio=0; db_estado=INICIAL.
//   Baud counter, bit index and snapshot registers all clear to 0.
//  Reset mid-frame aborts: saida_serial returns to 1 at the first edge with reset high.
//  FSM states and codes:
//   INICIAL=0, ENVIA_TEMP1=1, ENVIA_TEMP2=2, ENVIA_TEMP3=3, ENVIA_TEMP4=4,
//   ENVIA_UMIDADE=5, FIM_ENVIO=7 (code 6 unused, decodes to INICIAL).
//  INICIAL: enviar_config=1 at an edge -> snapshot all 5 words, go to ENVIA_TEMP1.
//   The start pulse is issued to the serializer in the same edge.
//  Latency: saida_serial=0 (start bit) in the first cycle after the accepting edge.
//  ENVIA_x: wait for serializer fim pulse -> next ENVIA state, issuing the next start.
//   Frames are back-to-back: the next start bit directly follows the previous
//   stop bit. No idle cycles between frames.
//  ENVIA_UMIDADE + fim -> FIM_ENVIO. FIM_ENVIO lasts 1 cycle (pronto_envio=1),
//   then unconditionally -> INICIAL.
//  ocupado=1 in states 1..5 and FIM_ENVIO; 0 in INICIAL.
//  enviar_config while ocupado=1 is ignored (no queueing, no restart).
//  enviar_config held high: a new transfer starts on the edge after return to INICIAL.
//  Inputs that change during a transfer do not affect the transfer; only snapshot values are sent.
//  Bit timing: each bit holds exactly CLKS_PER_BIT cycles.
//   Frame length = (DATA_BITS+3)*CLKS_PER_BIT.
//   Whole transfer = 5*(DATA_BITS+3)*CLKS_PER_BIT cycles, from start bit to end of last stop bit.
//  Parity bit = ^data (even parity: total ones in data+parity is even).
//  Baud counter wraps 0..CLKS_PER_BIT-1. Bit index 0..DATA_BITS+2; no overflow past stop.
// STRUCTURE
//  Shared include config_defs.vh holds:
//   - state codes
//   - DATA_BITS default
//   - PARITY_EVEN define (also used by the receiver's parity check)
//  Sub-module uart_tx_parity (DATA_BITS, CLKS_PER_BIT):
//   - ports: clock, reset, partida, dados, saida_serial, fim (1-cycle pulse at end of stop bit), ocupado_tx
//  Top level holds: FSM, snapshot registers, word mux driven by the state.
// TESTING (sim with CLKS_PER_BIT=4, DATA_BITS=7)
//  1. Reset, idle 20 cycles -> saida_serial=1, ocupado=0, pronto_envio never high.
//  2. temp1=7'h35, temp2=7'h01, temp3=7'h7F, temp4=7'h00, lim_um=7'h50, pulse enviar_config:
//     - frames decode to 35,01,7F,00,50 with parity 0,1,1,0,0
//     - pronto_envio pulses once, exactly 200 cycles after the first start bit.
//  3. Change all inputs to 7'h2A one bit-time into frame 1 -> all 5 decoded frames still carry the original values.
//  4. Pulse enviar_config during frame 3 -> no restart; total duration stays 200 cycles; one pronto_envio.
//  5. Hold enviar_config=1 -> two transfers; second start bit 2 cycles after the first pronto_envio.
//  6. Assert reset during parity bit of frame 2 -> next cycle saida_serial=1, db_estado=0;
//     a new request then sends a complete 5-frame transfer.

Source files
------------

// File: rtl/config_report_tx_pkg.sv
// config_report_tx_pkg
//   Shared definitions for the configuration link transmitter: FSM state codes,
//   default payload width / baud divider, and the parity sense that the
//   configuration receiver also uses for its parity check.
package config_report_tx_pkg;

  localparam int DATA_BITS_DEFAULT    = 7;
  localparam int CLKS_PER_BIT_DEFAULT = 434;  // 50 MHz / 115200

  // 1 = even parity (parity bit = XOR of data), 0 = odd parity
  localparam bit PARITY_EVEN = 1'b1;

  // Code 6 is intentionally unused; the FSM treats it as INICIAL.
  typedef enum logic [2:0] {
    INICIAL       = 3'd0,
    ENVIA_TEMP1   = 3'd1,
    ENVIA_TEMP2   = 3'd2,
    ENVIA_TEMP3   = 3'd3,
    ENVIA_TEMP4   = 3'd4,
    ENVIA_UMIDADE = 3'd5,
    FIM_ENVIO     = 3'd7
  } estado_t;

endpackage

// File: rtl/config_report_tx_uart_tx_parity.sv
// uart_tx_parity
//   Frame serializer: start(0), DATA_BITS data LSB-first, parity, stop(1).
//   Every bit is held for exactly CLKS_PER_BIT cycles.
// Ports
//   i_clock        system clock (rising edge)
//   i_reset        synchronous active-high reset; line returns to idle (1)
//   i_partida      start request; accepted when idle or in the last stop-bit cycle
//   i_dados        payload sampled together with i_partida
//   o_saida_serial serial line, registered, idle high
//   o_fim          high during the last cycle of the stop bit
//   o_ocupado_tx   high while a frame is on the line
module uart_tx_parity
  import config_report_tx_pkg::*;
#(
  parameter int DATA_BITS    = DATA_BITS_DEFAULT,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_partida,
  input  logic [DATA_BITS-1:0] i_dados,
  output logic                 o_saida_serial,
  output logic                 o_fim,
  output logic                 o_ocupado_tx
);

  localparam int FRAME_BITS = DATA_BITS + 3;
  localparam int BAUD_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W      = $clog2(FRAME_BITS);
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_STOP = IDX_W'(FRAME_BITS - 1);

  logic                 r_busy;
  logic [BAUD_W-1:0]    r_baud;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS+1:0] r_frame;   // bits still to send after the current one
  logic                 r_saida;
  logic                 w_fim;
  logic                 w_paridade;

  assign w_paridade = PARITY_EVEN ? (^i_dados) : ~(^i_dados);

  // End of stop bit: combinational so the caller can chain the next frame
  // on this very edge without an idle cycle.
  assign w_fim = r_busy && (r_idx == IDX_STOP) && (r_baud == BAUD_MAX);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_busy  <= 1'b0;
      r_baud  <= '0;
      r_idx   <= '0;
      r_frame <= '0;
      r_saida <= 1'b1;
    end else if (!r_busy || w_fim) begin
      if (i_partida) begin
        // Start bit goes on the line right away; the rest waits in r_frame.
        r_busy  <= 1'b1;
        r_baud  <= '0;
        r_idx   <= '0;
        r_frame <= {1'b1, w_paridade, i_dados};
        r_saida <= 1'b0;
      end else if (w_fim) begin
        r_busy  <= 1'b0;
        r_baud  <= '0;
        r_idx   <= '0;
        r_saida <= 1'b1;
      end
    end else if (r_baud == BAUD_MAX) begin
      r_baud  <= '0;
      r_idx   <= r_idx + 1'b1;
      r_saida <= r_frame[0];
      r_frame <= {1'b1, r_frame[DATA_BITS+1:1]};
    end else begin
      r_baud <= r_baud + 1'b1;
    end
  end

  assign o_saida_serial = r_saida;
  assign o_fim          = w_fim;
  assign o_ocupado_tx   = r_busy;

endmodule

// File: rtl/config_report_tx.sv
// config_report_tx
//   On request, snapshots the five configuration words and sends them back to
//   back as parity frames in the order temp1, temp2, temp3, temp4, lim_um.
// Ports
//   i_clock, i_reset        clock / synchronous active-high reset
//   i_enviar_config         transfer request (level, only honoured in INICIAL)
//   i_temp1..i_temp4        stored temperature thresholds
//   i_lim_um                stored humidity limit
//   o_saida_serial          serial line, idle high
//   o_ocupado               high from acceptance until pronto_envio
//   o_pronto_envio          one-cycle pulse after the last stop bit
//   o_db_estado             current FSM state code
module config_report_tx
  import config_report_tx_pkg::*;
#(
  parameter int DATA_BITS    = DATA_BITS_DEFAULT,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enviar_config,
  input  logic [DATA_BITS-1:0] i_temp1,
  input  logic [DATA_BITS-1:0] i_temp2,
  input  logic [DATA_BITS-1:0] i_temp3,
  input  logic [DATA_BITS-1:0] i_temp4,
  input  logic [DATA_BITS-1:0] i_lim_um,
  output logic                 o_saida_serial,
  output logic                 o_ocupado,
  output logic                 o_pronto_envio,
  output logic [2:0]           o_db_estado
);

  estado_t              r_estado;
  logic                 r_ocupado;
  logic                 r_pronto;
  // temp1 is captured directly by the serializer frame register at acceptance,
  // so only the remaining four words need holding here.
  logic [DATA_BITS-1:0] r_snap [4];

  logic                 w_partida;
  logic [DATA_BITS-1:0] w_dados;
  logic                 w_fim;
  logic                 w_ocupado_tx;

  // Start request and payload for the frame that begins on this edge.
  always_comb begin
    w_partida = 1'b0;
    w_dados   = i_temp1;
    case (r_estado)
      INICIAL:     w_partida = i_enviar_config && !w_ocupado_tx;
      ENVIA_TEMP1: begin w_partida = w_fim; w_dados = r_snap[0]; end
      ENVIA_TEMP2: begin w_partida = w_fim; w_dados = r_snap[1]; end
      ENVIA_TEMP3: begin w_partida = w_fim; w_dados = r_snap[2]; end
      ENVIA_TEMP4: begin w_partida = w_fim; w_dados = r_snap[3]; end
      default:     ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_estado  <= INICIAL;
      r_ocupado <= 1'b0;
      r_pronto  <= 1'b0;
      for (int i = 0; i < 4; i++) r_snap[i] <= '0;
    end else begin
      case (r_estado)
        INICIAL: begin
          if (w_partida) begin
            r_snap[0] <= i_temp2;
            r_snap[1] <= i_temp3;
            r_snap[2] <= i_temp4;
            r_snap[3] <= i_lim_um;
            r_estado  <= ENVIA_TEMP1;
            r_ocupado <= 1'b1;
          end
        end
        ENVIA_TEMP1:   if (w_fim) r_estado <= ENVIA_TEMP2;
        ENVIA_TEMP2:   if (w_fim) r_estado <= ENVIA_TEMP3;
        ENVIA_TEMP3:   if (w_fim) r_estado <= ENVIA_TEMP4;
        ENVIA_TEMP4:   if (w_fim) r_estado <= ENVIA_UMIDADE;
        ENVIA_UMIDADE: begin
          if (w_fim) begin
            r_estado <= FIM_ENVIO;
            r_pronto <= 1'b1;
          end
        end
        FIM_ENVIO: begin
          r_estado  <= INICIAL;
          r_ocupado <= 1'b0;
          r_pronto  <= 1'b0;
        end
        default: begin  // unused code 6
          r_estado  <= INICIAL;
          r_ocupado <= 1'b0;
          r_pronto  <= 1'b0;
        end
      endcase
    end
  end

  uart_tx_parity #(
    .DATA_BITS    (DATA_BITS),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_partida      (w_partida),
    .i_dados        (w_dados),
    .o_saida_serial (o_saida_serial),
    .o_fim          (w_fim),
    .o_ocupado_tx   (w_ocupado_tx)
  );

  assign o_ocupado      = r_ocupado;
  assign o_pronto_envio = r_pronto;
  assign o_db_estado    = r_estado;

endmodule

// File: tb/tb_config_report_tx.sv
// tb_config_report_tx
//   Directed bench for config_report_tx with CLKS_PER_BIT=4, DATA_BITS=7.
//   A logger records the line, pronto, ocupado and state code once per cycle;
//   frames are decoded from that record at mid-bit positions.
module tb_config_report_tx;

  localparam int DB    = 7;
  localparam int CPB   = 4;
  localparam int FRAME = (DB + 3) * CPB;   // 40
  localparam int XFER  = 5 * FRAME;        // 200
  localparam int LOGN  = 8192;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enviar = 1'b0;
  logic [DB-1:0] t1 = '0, t2 = '0, t3 = '0, t4 = '0, lum = '0;
  logic          saida, ocupado, pronto;
  logic [2:0]    estado;

  logic [DB-1:0] set_a [5] = '{7'h35, 7'h01, 7'h7F, 7'h00, 7'h50};
  logic          par_a [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [DB-1:0] set_b [5] = '{7'h2A, 7'h55, 7'h0F, 7'h70, 7'h3C};
  logic          par_b [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  int n_pass  = 0;
  int n_total = 0;

  int         cyc = 0;
  int         pronto_cnt = 0;
  logic       line_log [LOGN];
  logic       pronto_log [LOGN];
  logic       ocup_log [LOGN];
  logic [2:0] db_log [LOGN];

  config_report_tx #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB)) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_enviar_config (enviar),
    .i_temp1         (t1),
    .i_temp2         (t2),
    .i_temp3         (t3),
    .i_temp4         (t4),
    .i_lim_um        (lum),
    .o_saida_serial  (saida),
    .o_ocupado       (ocupado),
    .o_pronto_envio  (pronto),
    .o_db_estado     (estado)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (cyc < LOGN) begin
      line_log[cyc]   = saida;
      pronto_log[cyc] = pronto;
      ocup_log[cyc]   = ocupado;
      db_log[cyc]     = estado;
    end
    if (pronto) pronto_cnt = pronto_cnt + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %s: observed=%0h expected=%0h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_inputs(input logic [DB-1:0] w [5]);
    t1 = w[0]; t2 = w[1]; t3 = w[2]; t4 = w[3]; lum = w[4];
  endtask

  task automatic pulse_req();
    @(negedge clk) enviar = 1'b1;
    @(negedge clk) enviar = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Returns the cycle index of the first start-bit sample; bounded wait.
  task automatic wait_start(input string tag, output int s);
    int n;
    n = 0;
    while (saida !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_start_seen"}, int'(saida === 1'b0), 1);
    s = cyc;
  endtask

  // Waits out the transfer started at s and checks timing and all five frames.
  task automatic finish_transfer(input string tag, input int s,
                                 input logic [DB-1:0] w [5], input logic p [5]);
    int pc0, pcnt, first_p, base;
    logic [DB-1:0] d;
    wait_cyc(s + XFER + 5);
    first_p = -1;
    pcnt = 0;
    for (int c = s; c <= s + XFER + 4; c++) begin
      if (pronto_log[c] === 1'b1) begin
        if (first_p < 0) first_p = c;
        pcnt++;
      end
    end
    pc0 = pcnt;
    chk({tag, "_pronto_latency"}, first_p - s, XFER);
    chk({tag, "_pronto_count"}, pc0, 1);
    chk({tag, "_state_fim"}, int'(db_log[s + XFER]), 7);
    chk({tag, "_state_after"}, int'(db_log[s + XFER + 1]), 0);
    chk({tag, "_ocupado_after"}, int'(ocup_log[s + XFER + 1]), 0);
    for (int k = 0; k < 5; k++) begin
      base = s + k * FRAME + 1;
      for (int j = 0; j < DB; j++) d[j] = line_log[base + (j + 1) * CPB];
      chk($sformatf("%s_f%0d_start", tag, k), int'(line_log[base]), 0);
      chk($sformatf("%s_f%0d_data", tag, k), int'(d), int'(w[k]));
      chk($sformatf("%s_f%0d_parity", tag, k), int'(line_log[base + (DB + 1) * CPB]), int'(p[k]));
      chk($sformatf("%s_f%0d_stop", tag, k), int'(line_log[base + (DB + 2) * CPB]), 1);
    end
  endtask

  initial begin
    int s, s2, lows, pr0, ocs;

    // 1. reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_saida", int'(saida), 1);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_pronto", int'(pronto), 0);
    chk("rst_estado", int'(estado), 0);
    lows = 0; ocs = 0; pr0 = pronto_cnt;
    repeat (20) begin
      @(negedge clk);
      if (saida !== 1'b1) lows++;
      if (ocupado !== 1'b0) ocs++;
    end
    chk("idle_line_low", lows, 0);
    chk("idle_ocupado", ocs, 0);
    chk("idle_pronto", pronto_cnt - pr0, 0);

    // 2. basic transfer
    set_inputs(set_a);
    pulse_req();
    wait_start("t2", s);
    chk("t2_latency_state", int'(estado), 1);
    chk("t2_ocupado", int'(ocupado), 1);
    wait_cyc(s + 50);
    chk("t2_state_frame2", int'(estado), 2);
    finish_transfer("t2", s, set_a, par_a);

    // 3. inputs change one bit-time into frame 1
    repeat (5) @(negedge clk);
    pulse_req();
    wait_start("t3", s);
    wait_cyc(s + CPB);
    set_inputs('{7'h2A, 7'h2A, 7'h2A, 7'h2A, 7'h2A});
    finish_transfer("t3", s, set_a, par_a);
    set_inputs(set_a);

    // 4. request during frame 3 is ignored
    repeat (5) @(negedge clk);
    pulse_req();
    wait_start("t4", s);
    wait_cyc(s + 2 * FRAME + 10);
    pulse_req();
    finish_transfer("t4", s, set_a, par_a);
    wait_cyc(s + XFER + 15);
    lows = 0;
    for (int c = s + XFER + 1; c <= s + XFER + 15; c++) if (line_log[c] !== 1'b1) lows++;
    chk("t4_no_restart", lows, 0);

    // 5. request held high: back-to-back transfers
    @(negedge clk) enviar = 1'b1;
    @(negedge clk);
    wait_start("t5", s);
    set_inputs(set_b);
    finish_transfer("t5a", s, set_a, par_a);
    enviar = 1'b0;
    s2 = s + XFER + 2;
    chk("t5_gap_idle", int'(line_log[s2 - 1]), 1);
    chk("t5_second_start", int'(line_log[s2]), 0);
    finish_transfer("t5b", s2, set_b, par_b);

    // 6. reset during parity bit of frame 2
    repeat (5) @(negedge clk);
    pulse_req();
    wait_start("t6", s);
    wait_cyc(s + FRAME + (DB + 1) * CPB + 1);
    chk("t6_pre_parity", int'(saida), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_saida", int'(saida), 1);
    chk("t6_rst_estado", int'(estado), 0);
    chk("t6_rst_ocupado", int'(ocupado), 0);
    rst = 1'b0;
    set_inputs(set_a);
    repeat (5) @(negedge clk);
    pulse_req();
    wait_start("t6b", s);
    finish_transfer("t6b", s, set_a, par_a);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
